// File: rtl/plab3_mem_pkg.sv
// Shared definitions for the plab3 memory write path: FSM state encoding and word width.
package plab3_mem_pkg;

   localparam int WORD_NBITS = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      BUBBLE = 2'd2
   } wr_arb_state_e;

endpackage

// File: rtl/plab3_mem_wr_arbiter_if.sv
// Bundle of the two requester handshakes and the array write port.
// slave = the arbiter; master = the side driving requests and observing the array port.
interface plab3_mem_wr_arbiter_if
   import plab3_mem_pkg::*;
#(
   parameter int p_off_nbits = 2,
   parameter int p_idx_nbits = 8
);

   logic                                req0_val, req1_val;
   logic                                req0_rdy, req1_rdy;
   logic [p_idx_nbits-1:0]              req0_idx, req1_idx;
   logic [p_off_nbits-1:0]              req0_off, req1_off;
   logic [WORD_NBITS-1:0]               req0_data, req1_data;
   logic                                req0_domain, req1_domain;
   logic                                req0_ack, req1_ack;

   logic                                arr_wen;
   logic [p_idx_nbits-1:0]              arr_idx;
   logic [(1<<(p_off_nbits+2))-1:0]     arr_wben;
   logic [(WORD_NBITS<<p_off_nbits)-1:0] arr_wdata;
   logic                                arr_domain;

   modport slave (
      input  req0_val, req0_idx, req0_off, req0_data, req0_domain,
      input  req1_val, req1_idx, req1_off, req1_data, req1_domain,
      output req0_rdy, req0_ack, req1_rdy, req1_ack,
      output arr_wen, arr_idx, arr_wben, arr_wdata, arr_domain
   );

   modport master (
      output req0_val, req0_idx, req0_off, req0_data, req0_domain,
      output req1_val, req1_idx, req1_off, req1_data, req1_domain,
      input  req0_rdy, req0_ack, req1_rdy, req1_ack,
      input  arr_wen, arr_idx, arr_wben, arr_wdata, arr_domain
   );

endinterface

// File: rtl/plab3_mem_wben_gen.sv
// Word offset to byte enables: the four bytes of the addressed word are enabled.
module plab3_mem_wben_gen #(
   parameter int p_off_nbits = 2
) (
   input  logic [p_off_nbits-1:0]            off,
   output logic [(1<<(p_off_nbits+2))-1:0]   wben
);

   localparam int NBYTES = 1 << (p_off_nbits + 2);

   for (genvar i = 0; i < NBYTES; i++) begin : g_byte
      assign wben[i] = (off == p_off_nbits'(i / 4));
   end

endmodule

// File: rtl/plab3_mem_wr_arbiter.sv
// Two-requester round-robin arbiter feeding a single-word write into a line-wide array port.
// Optional feature: PLAB3_MEM_WR_ARB_DOMAIN_ISOLATE_EN inserts a bubble between cross-domain writes.
module plab3_mem_wr_arbiter
   import plab3_mem_pkg::*;
#(
   parameter int p_off_nbits = 2,
   parameter int p_idx_nbits = 8
) (
   input logic                      clk,
   input logic                      reset,
   plab3_mem_wr_arbiter_if.slave    bus
);

   localparam int NWORDS = 1 << p_off_nbits;
   localparam int NBYTES = 1 << (p_off_nbits + 2);

   wr_arb_state_e              state, state_next;
   logic                       ptr;
   logic [p_idx_nbits-1:0]     idx_q;
   logic [p_off_nbits-1:0]     off_q;
   logic [WORD_NBITS-1:0]      data_q;
   logic                       dom_q;
   logic                       win_q;

   logic                       sel_any, sel_both, sel_id, xfer;
   logic [NBYTES-1:0]          wben_raw;

   // Winner for this cycle; the pointer only breaks ties.
   assign sel_any  = bus.req0_val | bus.req1_val;
   assign sel_both = bus.req0_val & bus.req1_val;
   assign sel_id   = sel_both ? ptr : bus.req1_val;
   assign xfer     = (state == IDLE) && sel_any && !reset;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:   if (xfer) state_next = WRITE;
         WRITE: begin
            state_next = IDLE;
`ifdef PLAB3_MEM_WR_ARB_DOMAIN_ISOLATE_EN
            if (sel_any && ((sel_id ? bus.req1_domain : bus.req0_domain) != dom_q))
               state_next = BUBBLE;
`endif
         end
         BUBBLE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         ptr    <= 1'b0;
         idx_q  <= '0;
         off_q  <= '0;
         data_q <= '0;
         dom_q  <= 1'b0;
         win_q  <= 1'b0;
      end else begin
         state <= state_next;
         if (xfer) begin
            idx_q  <= sel_id ? bus.req1_idx    : bus.req0_idx;
            off_q  <= sel_id ? bus.req1_off    : bus.req0_off;
            data_q <= sel_id ? bus.req1_data   : bus.req0_data;
            dom_q  <= sel_id ? bus.req1_domain : bus.req0_domain;
            win_q  <= sel_id;
            if (sel_both) ptr <= ~sel_id;
         end
      end
   end

   plab3_mem_wben_gen #(.p_off_nbits(p_off_nbits)) u_wben (
      .off  (off_q),
      .wben (wben_raw)
   );

   // Reset gates the strobes combinationally so a write caught by reset is never acked.
   assign bus.req0_rdy   = (state == IDLE) && !reset && sel_any && !sel_id;
   assign bus.req1_rdy   = (state == IDLE) && !reset && sel_any &&  sel_id;
   assign bus.arr_wen    = (state == WRITE) && !reset;
   assign bus.req0_ack   = bus.arr_wen && !win_q;
   assign bus.req1_ack   = bus.arr_wen &&  win_q;
   assign bus.arr_wben   = bus.arr_wen ? wben_raw : '0;
   assign bus.arr_idx    = idx_q;
   assign bus.arr_domain = dom_q;
   assign bus.arr_wdata  = {NWORDS{data_q}};

endmodule
